// File: rtl/sp_if_order_seq_if.sv
// Bus bundle between the order sequencer, the order ROM and the SP I/F DDR controller.
// The master modport is the sequencer side; the slave modport is the ROM/controller side.
interface sp_if_order_seq_if #(
    parameter int P_ADR_W = 10
);
    logic [P_ADR_W-1:0] o_order_mem_rd_adr;
    logic               o_order_mem_rden;
    logic [31:0]        i_order_mem_rd_data;
    logic               o_cmd_vld;
    logic               i_cmd_rdy;
    logic               o_cmd_wr;
    logic [11:0]        o_cmd_len;
    logic [15:0]        o_cmd_adr;

    modport master (
        output o_order_mem_rd_adr, o_order_mem_rden,
        input  i_order_mem_rd_data,
        output o_cmd_vld, o_cmd_wr, o_cmd_len, o_cmd_adr,
        input  i_cmd_rdy
    );

    modport slave (
        input  o_order_mem_rd_adr, o_order_mem_rden,
        output i_order_mem_rd_data,
        input  o_cmd_vld, o_cmd_wr, o_cmd_len, o_cmd_adr,
        output i_cmd_rdy
    );
endinterface

// File: rtl/sp_if_order_seq.sv
// SP I/F order sequencer: fetches order words from the order ROM, decodes them and
// issues DDR read/write commands over a valid/ready handshake until END, abort or error.
module sp_if_order_seq #(
    parameter int P_ROM_LAT = 2,
    parameter int P_ADR_W   = 10
) (
    input  logic               i_clk156m,
    input  logic               i_arst,
    input  logic               i_start,
    input  logic [P_ADR_W-1:0] i_start_adr,
    input  logic               i_abort,
    sp_if_order_seq_if.master  io_bus,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_CMD, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LP_OP_WRITE = 4'h1;
    localparam logic [3:0] LP_OP_READ  = 4'h2;
    localparam logic [3:0] LP_OP_WAIT  = 4'h3;
    localparam logic [3:0] LP_OP_JUMP  = 4'h4;
    localparam logic [1:0] LP_LAT      = 2'(P_ROM_LAT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_lat_cnt;
    logic [P_ADR_W-1:0] r_pc;
    logic [31:0]        r_order;
    logic [15:0]        r_wait_cnt;
    logic [11:0]        r_loop_cnt;
    logic               r_loop_act;
    logic               r_cmd_wr;
    logic [11:0]        r_cmd_len;
    logic [15:0]        r_cmd_adr;
    logic               r_err;

    logic [3:0]         w_op;
    logic [11:0]        w_len;
    logic [15:0]        w_arg16;
    logic [P_ADR_W-1:0] w_tgt;
    logic [P_ADR_W-1:0] w_pc_inc;
    logic               w_fetch_issue;

    assign w_op          = r_order[31:28];
    assign w_len         = r_order[27:16];
    assign w_arg16       = r_order[15:0];
    assign w_tgt         = r_order[P_ADR_W-1:0];
    assign w_pc_inc      = P_ADR_W'(r_pc + 1'b1);
    assign w_fetch_issue = (r_state == S_FETCH) && (r_lat_cnt == 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk156m or posedge i_arst) begin
        if (i_arst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (w_fetch_issue && i_abort) w_state_nxt = S_DONE;
                else if (r_lat_cnt == LP_LAT) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (i_abort) w_state_nxt = S_DONE;
                else begin
                    case (w_op)
                        LP_OP_WRITE, LP_OP_READ: w_state_nxt = (w_len != 12'd0) ? S_CMD : S_FETCH;
                        LP_OP_WAIT:              w_state_nxt = (w_arg16 != 16'd0) ? S_WAIT : S_FETCH;
                        LP_OP_JUMP:              w_state_nxt = S_FETCH;
                        default:                 w_state_nxt = S_DONE;
                    endcase
                end
            end
            // The handshake is never withdrawn; a pending abort is honoured once the command is taken.
            S_CMD:    if (io_bus.i_cmd_rdy) w_state_nxt = i_abort ? S_DONE : S_FETCH;
            S_WAIT: begin
                if (i_abort) w_state_nxt = S_DONE;
                else if (r_wait_cnt == 16'd1) w_state_nxt = S_FETCH;
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy                  = (r_state != S_IDLE);
        o_done                  = (r_state == S_DONE);
        io_bus.o_order_mem_rden = w_fetch_issue;
        io_bus.o_cmd_vld        = (r_state == S_CMD);
    end

    assign io_bus.o_order_mem_rd_adr = r_pc;
    assign io_bus.o_cmd_wr           = r_cmd_wr;
    assign io_bus.o_cmd_len          = r_cmd_len;
    assign io_bus.o_cmd_adr          = r_cmd_adr;
    assign o_err                     = r_err;

    always_ff @(posedge i_clk156m or posedge i_arst) begin
        if (i_arst) begin
            r_lat_cnt  <= '0;
            r_pc       <= '0;
            r_order    <= '0;
            r_wait_cnt <= '0;
            r_loop_cnt <= '0;
            r_loop_act <= 1'b0;
            r_cmd_wr   <= 1'b0;
            r_cmd_len  <= '0;
            r_cmd_adr  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_lat_cnt <= (r_state == S_FETCH && w_state_nxt == S_FETCH) ? r_lat_cnt + 2'd1 : 2'd0;
            if (r_state == S_FETCH && r_lat_cnt == LP_LAT) r_order <= io_bus.i_order_mem_rd_data;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc       <= i_start_adr;
                        r_err      <= 1'b0;
                        r_loop_act <= 1'b0;
                        r_loop_cnt <= '0;
                    end
                end
                S_DECODE: begin
                    if (!i_abort) begin
                        case (w_op)
                            LP_OP_WRITE, LP_OP_READ: begin
                                if (w_len != 12'd0) begin
                                    r_cmd_wr  <= (w_op == LP_OP_WRITE);
                                    r_cmd_len <= w_len;
                                    r_cmd_adr <= w_arg16;
                                end else begin
                                    r_err <= 1'b1;
                                    r_pc  <= w_pc_inc;
                                end
                            end
                            LP_OP_WAIT: begin
                                r_wait_cnt <= w_arg16;
                                if (w_arg16 == 16'd0) r_pc <= w_pc_inc;
                            end
                            // Single-level loop: N==0 jumps forever, otherwise the body runs N+1 times.
                            LP_OP_JUMP: begin
                                if (w_len == 12'd0) begin
                                    r_pc <= w_tgt;
                                end else if (!r_loop_act) begin
                                    r_loop_cnt <= w_len - 12'd1;
                                    r_loop_act <= 1'b1;
                                    r_pc       <= w_tgt;
                                end else if (r_loop_cnt != 12'd0) begin
                                    r_loop_cnt <= r_loop_cnt - 12'd1;
                                    r_pc       <= w_tgt;
                                end else begin
                                    r_loop_act <= 1'b0;
                                    r_pc       <= w_pc_inc;
                                end
                            end
                            4'h0:    ;
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                S_CMD:  if (io_bus.i_cmd_rdy) r_pc <= w_pc_inc;
                S_WAIT: begin
                    if (!i_abort) begin
                        r_wait_cnt <= r_wait_cnt - 16'd1;
                        if (r_wait_cnt == 16'd1) r_pc <= w_pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_if_order_seq.sv
// Self-checking bench for sp_if_order_seq: an order-program interpreter predicts the command
// stream into a scoreboard queue; a monitor pops and compares every accepted command.
module tb_sp_if_order_seq;
    localparam int L  = 2;
    localparam int AW = 10;

    typedef struct packed {
        logic        wr;
        logic [11:0] len;
        logic [15:0] adr;
    } cmd_t;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_adr = '0;
    logic          busy, done, err;

    sp_if_order_seq_if #(.P_ADR_W(AW)) bus ();

    sp_if_order_seq #(.P_ROM_LAT(L), .P_ADR_W(AW)) dut (
        .i_clk156m   (clk),
        .i_arst      (arst),
        .i_start     (start),
        .i_start_adr (start_adr),
        .i_abort     (abort),
        .io_bus      (bus.master),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done = 0;
    int n_acc  = 0;
    int rdy_mode = 1;       // 0: hold low, 1: hold high, 2: random
    cmd_t exp_q[$];
    int   rden_t[$];
    int   rden_a[$];

    // ROM model: address register then P_ROM_LAT-1 output stages.
    logic [31:0] rom  [1024];
    logic [31:0] pipe [L];
    always @(posedge clk) begin
        if (bus.o_order_mem_rden) pipe[0] <= rom[bus.o_order_mem_rd_adr];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.i_order_mem_rd_data = pipe[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        bus.i_cmd_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_cmd_rdy = 1'b0;
                1:       bus.i_cmd_rdy = 1'b1;
                default: bus.i_cmd_rdy = 1'($urandom % 2);
            endcase
        end
    end

    // Monitor: scoreboard pops, handshake stability and done/busy relation.
    initial begin
        logic prev_vld, prev_rdy, prev_done;
        cmd_t prev_cmd, cur, e;
        prev_vld = 0; prev_rdy = 0; prev_done = 0; prev_cmd = '0;
        forever begin
            @(negedge clk);
            if (arst) begin
                prev_vld = 0; prev_rdy = 0; prev_done = 0;
            end else begin
                cur = '{wr: bus.o_cmd_wr, len: bus.o_cmd_len, adr: bus.o_cmd_adr};
                if (bus.o_order_mem_rden) begin
                    rden_t.push_back(cyc);
                    rden_a.push_back(int'(bus.o_order_mem_rd_adr));
                end
                if (prev_vld && !prev_rdy) begin
                    check("hold_vld", 64'(bus.o_cmd_vld), 64'd1);
                    check("hold_fields", 64'(cur), 64'(prev_cmd));
                end
                if (bus.o_cmd_vld && bus.i_cmd_rdy) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_cmd: got %0h expected no command", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd", 64'(cur), 64'(e));
                    end
                end
                if (prev_done) check("busy_after_done", 64'(busy), 64'd0);
                if (done) n_done++;
                prev_vld = bus.o_cmd_vld; prev_rdy = bus.i_cmd_rdy;
                prev_done = done; prev_cmd = cur;
            end
        end
    end

    // Reference interpreter: walks the order program and predicts commands and error flag.
    task automatic model(input logic [AW-1:0] sa, output logic e);
        logic [AW-1:0] pc;
        int            remaining;   // extra passes left in the active loop, -1 when none
        logic [31:0]   w;
        pc = sa; remaining = -1; e = 1'b0;
        for (int s = 0; s < 4000; s++) begin
            w = rom[pc];
            case (w[31:28])
                4'h0: return;
                4'h1, 4'h2: begin
                    if (w[27:16] == 12'd0) e = 1'b1;
                    else exp_q.push_back('{wr: (w[31:28] == 4'h1), len: w[27:16], adr: w[15:0]});
                    pc = pc + 1'b1;
                end
                4'h3: pc = pc + 1'b1;
                4'h4: begin
                    if (remaining < 0) remaining = int'(w[27:16]);
                    if (remaining > 0) begin
                        remaining--;
                        pc = w[AW-1:0];
                    end else begin
                        remaining = -1;
                        pc = pc + 1'b1;
                    end
                end
                default: begin
                    e = 1'b1;
                    return;
                end
            endcase
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] sa);
        @(posedge clk); #1;
        start_adr = sa; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_prog(input logic [AW-1:0] sa, input int budget);
        int   d0, t;
        logic me;
        model(sa, me);
        d0 = n_done;
        rden_t.delete(); rden_a.delete();
        pulse_start(sa);
        @(negedge clk);
        check("err_clr_on_start", 64'(err), 64'd0);
        check("busy_after_start", 64'(busy), 64'd1);
        t = 0;
        while (n_done == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_once", 64'(n_done - d0), 64'd1);
        check("cmd_q_drained", 64'(exp_q.size()), 64'd0);
        check("err_final", 64'(err), 64'(me));
        check("idle_after", 64'(busy), 64'd0);
        if (n_done == d0) begin
            exp_q.delete();
            @(posedge clk); #1 arst = 1'b1;
            @(posedge clk); #1 arst = 1'b0;
        end
    endtask

    function automatic logic [43:0] outs();
        return {bus.o_order_mem_rd_adr, bus.o_order_mem_rden, bus.o_cmd_vld, bus.o_cmd_wr,
                bus.o_cmd_len, bus.o_cmd_adr, busy, done, err};
    endfunction

    initial begin
        int   acc0, d0, k, got, n;
        logic [AW-1:0] base, a;
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;

        // Reset with random inputs: every output low, no fetch.
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom % 2); abort = 1'($urandom % 2); start_adr = AW'($urandom);
            @(negedge clk);
            check("reset_outputs", 64'(outs()), 64'd0);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; arst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", 64'(outs() & ~44'(1 << 34)), 64'd0);

        // Basic program, back-to-back acceptance.
        rdy_mode = 1;
        rom[5] = 32'h1010_1234; rom[6] = 32'h2004_00AA; rom[7] = 32'h0;
        run_prog(10'd5, 200);
        check("basic_rden_cnt", 64'(rden_t.size()), 64'd3);
        if (rden_t.size() == 3) begin
            check("basic_rden_space0", 64'(rden_t[1] - rden_t[0]), 64'(L + 3));
            check("basic_rden_space1", 64'(rden_t[2] - rden_t[1]), 64'(L + 3));
            check("basic_rden_adr2", 64'(rden_a[2]), 64'd7);
        end

        // Backpressure: command held for many cycles before acceptance.
        rdy_mode = 0;
        rom[20] = 32'h17FF_BEEF; rom[21] = 32'h0;
        acc0 = n_acc;
        fork
            run_prog(10'd20, 300);
            begin
                k = 0;
                while (!bus.o_cmd_vld && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check("bp_vld_seen", 64'(bus.o_cmd_vld), 64'd1);
                repeat (7) @(negedge clk);
                rdy_mode = 1;
            end
        join
        check("bp_single_accept", 64'(n_acc - acc0), 64'd1);
        check("bp_rden_cnt", 64'(rden_t.size()), 64'd2);

        // Loop: body runs N+1 = 3 times.
        rdy_mode = 2;
        rom[0] = 32'h2001_0000; rom[1] = 32'h4002_0000; rom[2] = 32'h0;
        acc0 = n_acc;
        run_prog(10'd0, 400);
        check("loop_reads", 64'(n_acc - acc0), 64'd3);

        // WAIT 5 at the top of the address space, PC wraps to 0.
        rdy_mode = 1;
        rom[1023] = 32'h3000_0005; rom[0] = 32'h0;
        run_prog(10'd1023, 200);
        check("wait_rden_cnt", 64'(rden_t.size()), 64'd2);
        if (rden_t.size() == 2) begin
            check("wait_spacing", 64'(rden_t[1] - rden_t[0]), 64'(L + 7));
            check("wrap_adr", 64'(rden_a[1]), 64'd0);
        end

        // Illegal opcode, then zero-length order skipped with error.
        rom[50] = 32'hF000_0000;
        run_prog(10'd50, 200);
        rom[60] = 32'h1000_0123; rom[61] = 32'h2003_0456; rom[62] = 32'h0;
        run_prog(10'd60, 200);

        // Abort inside an endless JUMP loop.
        rom[100] = 32'h4000_0064;
        acc0 = n_acc;
        d0 = n_done;
        pulse_start(10'd100);
        repeat ($urandom_range(5, 40)) @(posedge clk);
        #1 abort = 1'b1;
        got = 0;
        for (int i = 0; i < L + 3 && got == 0; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("abort_done_bound", 64'(got), 64'd1);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle", 64'(busy), 64'd0);
        check("abort_done_once", 64'(n_done - d0), 64'd1);
        check("abort_no_cmd", 64'(n_acc - acc0), 64'd0);

        // Randomised programs under random backpressure.
        rdy_mode = 2;
        for (int it = 0; it < 25; it++) begin
            base = AW'($urandom);
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) begin
                a = base + AW'(i);
                case ($urandom % 10)
                    0, 1, 2, 3: rom[a] = {4'h1, 12'($urandom_range(1, 4095)), 16'($urandom)};
                    4, 5, 6:    rom[a] = {4'h2, 12'($urandom_range(1, 4095)), 16'($urandom)};
                    7:          rom[a] = {4'h3, 12'($urandom), 16'($urandom_range(0, 4))};
                    8:          rom[a] = {4'h1, 12'h0, 16'($urandom)};
                    default:    rom[a] = ($urandom % 3 == 0) ? {4'($urandom_range(5, 15)), 28'($urandom)}
                                                              : {4'h2, 12'h001, 16'($urandom)};
                endcase
            end
            a = base + AW'(n);
            if ($urandom % 2 == 1) begin
                rom[a] = {4'h4, 12'($urandom_range(1, 3)), 6'd0, base};
                a = a + 1'b1;
            end
            rom[a] = 32'h0;
            run_prog(base, 3000);
        end

        // Reset in the middle of a long WAIT: immediate return to reset values, no done.
        rom[200] = 32'h3000_0100; rom[201] = 32'h0;
        d0 = n_done;
        pulse_start(10'd200);
        repeat (20) @(posedge clk);
        #1 arst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", 64'(outs()), 64'd0);
        @(posedge clk); #1 arst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 64'(n_done - d0), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
